// File: rtl/lcd_byte_transfer_if.sv
// Command channel between the LCD sequencer and the byte transfer block.
// Master issues one command/data byte per valid/ready handshake; slave pulses done.
interface lcd_byte_transfer_if #(
  parameter int DELAY_W = 21
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_rs;
  logic               cmd_single;
  logic [7:0]         cmd_data;
  logic [DELAY_W-1:0] cmd_delay;
  logic               cmd_done;

  modport master (
    output cmd_valid, cmd_rs, cmd_single, cmd_data, cmd_delay,
    input  cmd_ready, cmd_done
  );

  modport slave (
    input  cmd_valid, cmd_rs, cmd_single, cmd_data, cmd_delay,
    output cmd_ready, cmd_done
  );
endinterface

// File: rtl/lcd_byte_transfer.sv
// Drives one HD44780 byte (4-bit nibble pair, single nibble or 8-bit) with timed E strobe,
// then waits cmd_delay cycles and pulses cmd_done; cmd_ready only while idle, nothing is queued.
module lcd_byte_transfer #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BUS_W      = 4,
  parameter int SETUP_US   = 1,
  parameter int E_PULSE_US = 3,
  parameter int HOLD_US    = 1,
  parameter int DELAY_W    = 21
) (
  input  logic                CLK,
  input  logic                RST_N,
  lcd_byte_transfer_if.slave  cmd,
  output logic [BUS_W-1:0]    LCD_D,
  output logic                LCD_RS,
  output logic                LCD_E
);
  localparam int CYC_US = CLK_FREQ / 1000000;
  localparam int S_CYC  = (CYC_US * SETUP_US   > 1) ? CYC_US * SETUP_US   : 1;
  localparam int P_CYC  = (CYC_US * E_PULSE_US > 1) ? CYC_US * E_PULSE_US : 1;
  localparam int H_CYC  = (CYC_US * HOLD_US    > 1) ? CYC_US * HOLD_US    : 1;
  localparam int SP_MAX = (S_CYC > P_CYC) ? S_CYC : P_CYC;
  localparam int T_MAX  = (SP_MAX > H_CYC) ? SP_MAX : H_CYC;
  localparam int TW     = $clog2(T_MAX + 1);

  localparam logic [TW-1:0] S_LAST = TW'(S_CYC - 1);
  localparam logic [TW-1:0] P_LAST = TW'(P_CYC - 1);
  localparam logic [TW-1:0] H_LAST = TW'(H_CYC - 1);

  generate
    if (BUS_W != 4 && BUS_W != 8) begin : g_bad_bus_w
      $error("lcd_byte_transfer: BUS_W must be 4 or 8");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, DELAY} state_t;

  state_t             state;
  logic [TW-1:0]      tcnt;
  logic [DELAY_W-1:0] dcnt;
  logic [DELAY_W-1:0] dly_q;
  logic [BUS_W-1:0]   lo_q;
  logic               second_q;
  logic               done_q;

  assign cmd.cmd_ready = (state == IDLE);
  assign cmd.cmd_done  = done_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      tcnt     <= '0;
      dcnt     <= '0;
      dly_q    <= '0;
      lo_q     <= '0;
      second_q <= 1'b0;
      done_q   <= 1'b0;
      LCD_D    <= '0;
      LCD_RS   <= 1'b0;
      LCD_E    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd.cmd_valid) begin
            LCD_RS   <= cmd.cmd_rs;
            LCD_D    <= cmd.cmd_data[7 -: BUS_W];
            lo_q     <= BUS_W'(cmd.cmd_data[3:0]);
            second_q <= (BUS_W == 4) && !cmd.cmd_single;
            dly_q    <= cmd.cmd_delay;
            tcnt     <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (tcnt == S_LAST) begin
            tcnt  <= '0;
            LCD_E <= 1'b1;
            state <= PULSE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        PULSE: begin
          if (tcnt == P_LAST) begin
            tcnt  <= '0;
            LCD_E <= 1'b0;
            state <= HOLD;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        HOLD: begin
          if (tcnt == H_LAST) begin
            tcnt <= '0;
            // Low nibble reuses the full setup/pulse/hold sequence.
            if (second_q) begin
              LCD_D    <= lo_q;
              second_q <= 1'b0;
              state    <= SETUP;
            end else begin
              LCD_D  <= '0;
              LCD_RS <= 1'b0;
              dcnt   <= '0;
              if (dly_q == '0) begin
                done_q <= 1'b1;
                state  <= IDLE;
              end else begin
                state <= DELAY;
              end
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DELAY: begin
          if (dcnt == dly_q - 1'b1) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
